// File: rtl/tag_collector_pkg.sv
// Shared widths and the FIFO entry layout for the tag collector.
// Helper functions size the channel-id and level fields from module parameters.
package tag_collector_pkg;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int lvl_w(input int d);
      return $clog2(d) + 1;
   endfunction

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_TAG_W  = 16;
   localparam int DEF_CH_W   = ch_w(DEF_NUM_CH);

   typedef struct packed {
      logic [DEF_CH_W-1:0]  ch_id;
      logic [DEF_TAG_W-1:0] tag;
   } entry_t;

endpackage

// File: rtl/tag_collector_fifo_rr_arbiter.sv
// Round-robin grant over the pending channels; pointer advances past each grant.
// A first pass looks at or after the pointer, a second pass wraps to index 0.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic              clk_0,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] gnt,
   output logic [CH_W-1:0]   gnt_idx,
   output logic              gnt_any
);

   logic [CH_W-1:0] rr_ptr;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (!gnt_any && req[c] && (CH_W'(c) >= rr_ptr)) begin
            gnt_any = 1'b1;
            gnt[c]  = 1'b1;
            gnt_idx = CH_W'(c);
         end
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (!gnt_any && req[c]) begin
            gnt_any = 1'b1;
            gnt[c]  = 1'b1;
            gnt_idx = CH_W'(c);
         end
      end
   end

   always_ff @(posedge clk_0) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
   end

endmodule

// File: rtl/tag_collector_fifo.sv
// Collects tags from NUM_CH channels through one-entry pending registers into a
// shared FIFO, counting tags lost while a channel's pending slot is occupied.
module tag_collector_fifo
   import tag_collector_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int TAG_W  = 16,
   parameter int DEPTH  = 16,
   parameter int DROP_W = 8
) (
   input  logic                              clk_0,
   input  logic                              rst,
   input  logic [NUM_CH*TAG_W-1:0]           tag_in,
   input  logic [NUM_CH-1:0]                 tag_valid,
   input  logic                              drop_clr,
   input  logic                              rd_en,
   output logic [ch_w(NUM_CH)+TAG_W-1:0]     data_out,
   output logic                              data_valid,
   output logic                              empty,
   output logic                              full,
   output logic [lvl_w(DEPTH)-1:0]           level,
   output logic [NUM_CH*DROP_W-1:0]          drop_count
);

   localparam int CH_W  = ch_w(NUM_CH);
   localparam int LVL_W = lvl_w(DEPTH);
   localparam int AW    = $clog2(DEPTH);
   localparam int E_W   = CH_W + TAG_W;

   logic [NUM_CH-1:0] pend_vld;
   logic [TAG_W-1:0]  pend_tag [NUM_CH];
   logic [E_W-1:0]    mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] gnt;
   logic [CH_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic              rd_acc;

   assign empty  = (level == '0);
   assign full   = (level == LVL_W'(DEPTH));
   // Grants are gated by the registered full flag, so a read never frees a slot
   // for a write in the same cycle.
   assign req    = pend_vld & {NUM_CH{~full}};
   assign rd_acc = rd_en & ~empty;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .clk_0   (clk_0),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_ff @(posedge clk_0) begin
      if (rst) begin
         pend_vld   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         drop_count <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (tag_valid[c] && (!pend_vld[c] || gnt[c])) begin
               pend_vld[c] <= 1'b1;
               pend_tag[c] <= tag_in[c*TAG_W +: TAG_W];
            end else if (gnt[c]) begin
               pend_vld[c] <= 1'b0;
            end

            if (drop_clr) begin
               drop_count[c*DROP_W +: DROP_W] <= '0;
            end else if (tag_valid[c] && pend_vld[c] && !gnt[c] &&
                         (drop_count[c*DROP_W +: DROP_W] != '1)) begin
               drop_count[c*DROP_W +: DROP_W] <= drop_count[c*DROP_W +: DROP_W] + DROP_W'(1);
            end
         end

         if (gnt_any) begin
            mem[wr_ptr] <= {gnt_idx, pend_tag[gnt_idx]};
            wr_ptr      <= wr_ptr + AW'(1);
         end

         if (rd_acc) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + AW'(1);
         end
         data_valid <= rd_acc;

         unique case ({gnt_any, rd_acc})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: doc/tag_collector_fifo.md
TAG_COLLECTOR_FIFO -- requirements
Module: tag_collector_fifo

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of tag channels (2..16).
REQ-002 SHALL have parameter TAG_W, default 16, tag width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=4).
REQ-004 SHALL have parameter DROP_W, default 8, per-channel drop-counter width.
REQ-005 SHALL have one clock and one reset: the clock is clk_0; the reset is rst, synchronous and active-high.
REQ-006 SHALL have the following ports, clock and reset first:
  clk_0  in  1  sole clock
  rst  in  1  synchronous active-high reset
  tag_in  in  NUM_CH*TAG_W  channel c tag at bits [c*TAG_W +: TAG_W]
  tag_valid  in  NUM_CH  one-cycle tag strobe per channel
  drop_clr  in  1  clears all drop counters
  rd_en  in  1  read request
  data_out  out  CH_W+TAG_W  {channel id, tag}; CH_W = $clog2(NUM_CH)
  data_valid  out  1  data_out valid this cycle
  empty  out  1  FIFO holds no entries
  full  out  1  FIFO holds DEPTH entries
  level  out  $clog2(DEPTH)+1  current entry count
  drop_count  out  NUM_CH*DROP_W  per-channel dropped-tag counts

Function
REQ-007 SHALL give each channel a one-entry pending register; tag_valid loads tag_in into it when it is empty or being granted in the same cycle.
REQ-008 SHALL drop a tag arriving while its pending register is occupied and not granted that cycle, and increment that channel's drop counter, saturating at all-ones.
REQ-009 SHALL grant at most one pending channel per cycle, only when full is low at the start of the cycle.
REQ-010 SHALL arbitrate round-robin: grant the lowest-index pending channel at or after pointer rr_ptr, modulo NUM_CH, then set rr_ptr to granted index +1 mod NUM_CH; rr_ptr is unchanged when nothing is granted.
REQ-011 SHALL write {channel id, pending tag} into the FIFO on a grant and clear that pending register in the same edge.
REQ-012 Tag-to-FIFO latency SHALL be 2 cycles minimum: capture at edge N, write at edge N+1, visible in level after edge N+1.
REQ-013 SHALL accept a read when rd_en is high and empty is low; rd_en while empty SHALL be ignored with no state change.
REQ-014 SHALL present read data registered: accepted read at edge N gives data_valid=1 and data_out after edge N, for one cycle; otherwise data_valid=0 and data_out holds its last value.
REQ-015 SHALL allow simultaneous write and read; level is unchanged, including when the FIFO holds DEPTH entries at the start of the cycle only if no write occurs (REQ-009).
REQ-016 SHALL wrap read and write pointers modulo DEPTH; full = (level == DEPTH), empty = (level == 0).
REQ-017 SHALL clear all drop counters on drop_clr; a drop in the same cycle as drop_clr leaves that counter at 0.
REQ-018 SHALL preserve FIFO order; per-channel order SHALL be the order of capture.

Reset
REQ-019 On rst, SHALL clear all pending registers, FIFO pointers, rr_ptr and drop counters.
REQ-020 After rst: data_out=0, data_valid=0, empty=1, full=0, level=0, drop_count=0.
REQ-021 SHALL take rst in priority over all other inputs; tags and reads arriving during rst are discarded.

Structure
REQ-022 SHALL place the CH_W width function, the entry struct {ch_id, tag} and the level-width function in package tag_collector_pkg.
REQ-023 SHALL implement the round-robin grant as sub-module rr_arbiter (request vector in, one-hot grant and index out, pointer internal); FIFO storage is inline register array.

Verification
REQ-024 Single tag: channel 2 strobes 0x1234 with FIFO empty -> level=1 after 2 edges; rd_en -> data_valid with data_out={2,0x1234}.
REQ-025 All channels strobe together at rr_ptr=0 -> FIFO entries ordered ch0,ch1,ch2,ch3 over 4 cycles; rr_ptr ends at 0.
REQ-026 Fill to DEPTH with no reads, then channel 1 strobes twice -> full=1, first tag held pending, second dropped, drop_count[1]=1.
REQ-027 Read while full with ch0 pending -> no write that cycle, level=DEPTH-1; next cycle ch0 written, level=DEPTH.
REQ-028 2^DROP_W+3 drops on channel 3 -> counter saturates at all-ones; drop_clr -> 0.
REQ-029 Assert rst with 5 entries and 2 pending -> next cycle empty=1, level=0, data_valid=0, no stale data on later reads.
